wbc_vic_arb: RTL and testbench



---
 rtl/wbc_vic_pkg.sv | 22 ++
 rtl/wbc_rr_pick.sv | 37 +++
 rtl/wbc_vic_arb.sv | 159 +++++++++++++++
 tb/tb_wbc_vic_arb.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/wbc_vic_pkg.sv
// Shared types and helpers for the VIC acknowledge arbiter.
// Holds the FSM state encoding and the request-vector to level decode.
package wbc_vic_pkg;

    localparam int unsigned TMO_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STB  = 2'd1,
        REL  = 2'd2
    } vic_state_e;

    // Bit 3 of the slice is irq[7], so the highest set bit maps to level 7..4.
    function automatic logic [2:0] vic_level(input logic [3:0] v);
        if (v[3])      return 3'd7;
        else if (v[2]) return 3'd6;
        else if (v[1]) return 3'd5;
        else if (v[0]) return 3'd4;
        else           return 3'd0;
    endfunction

endpackage

// File: rtl/wbc_rr_pick.sv
// Combinational round-robin pick: maximum level over all controllers and the
// first controller at that level scanning upward from the rr pointer.
module wbc_rr_pick #(
    parameter int unsigned M  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [M*3-1:0] i_lvls,
    input  logic [IW-1:0]  i_rr,
    output logic [IW-1:0]  o_win,
    output logic [2:0]     o_maxlvl
);

    logic w_found;

    always_comb begin
        o_maxlvl = '0;
        for (int unsigned k = 0; k < M; k++) begin
            if (i_lvls[k*3 +: 3] > o_maxlvl) begin
                o_maxlvl = i_lvls[k*3 +: 3];
            end
        end
    end

    always_comb begin
        o_win   = i_rr;
        w_found = 1'b0;
        for (int unsigned i = 0; i < M; i++) begin
            int unsigned idx;
            idx = (32'(i_rr) + i) % M;
            if (!w_found && (i_lvls[idx*3 +: 3] == o_maxlvl)) begin
                o_win   = IW'(idx);
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wbc_vic_arb.sv
// Arbitrates M vectored interrupt controllers onto one CPU acknowledge path
// and sequences the strobe/ack vector fetch with a timeout.
module wbc_vic_arb
    import wbc_vic_pkg::*;
#(
    parameter int unsigned M   = 2,
    parameter int unsigned TMO = 15
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic [2:0]      cpu_pri_i,
    output logic            cpu_irq_o,
    input  logic            cpu_iak_i,
    output logic [15:0]     cpu_vec_o,
    output logic            cpu_vrdy_o,
    output logic            cpu_verr_o,
    input  logic [M*4-1:0]  vic_irq_i,
    output logic [M-1:0]    vic_stb_o,
    input  logic [M-1:0]    vic_ack_i,
    input  logic [M*16-1:0] vic_dat_i
);

    localparam int unsigned IW = (M > 1) ? $clog2(M) : 1;

    vic_state_e       r_state, w_state_n;
    logic [IW-1:0]    r_sel, w_sel_n;
    logic [IW-1:0]    r_rr, w_rr_n;
    logic [TMO_W-1:0] r_cnt, w_cnt_n;
    logic [M-1:0]     r_stb, w_stb_n;
    logic [15:0]      r_vec, w_vec_n;
    logic             r_vrdy, w_vrdy_n;
    logic             r_verr, w_verr_n;
    logic             r_irq, w_irq_n;

    logic [M*3-1:0]   w_lvls;
    logic [IW-1:0]    w_win;
    logic [2:0]       w_maxlvl;
    logic             w_elig;
    logic             w_ack_sel;
    logic [15:0]      w_dat_sel;

    always_comb begin
        w_lvls = '0;
        for (int unsigned k = 0; k < M; k++) begin
            w_lvls[k*3 +: 3] = vic_level(vic_irq_i[k*4 +: 4]);
        end
    end

    wbc_rr_pick #(
        .M  (M),
        .IW (IW)
    ) u_pick (
        .i_lvls   (w_lvls),
        .i_rr     (r_rr),
        .o_win    (w_win),
        .o_maxlvl (w_maxlvl)
    );

    assign w_elig = (w_maxlvl > cpu_pri_i);

    // Only the latched controller's ack/data matter; others are ignored.
    always_comb begin
        w_ack_sel = 1'b0;
        w_dat_sel = '0;
        for (int unsigned k = 0; k < M; k++) begin
            if (IW'(k) == r_sel) begin
                w_ack_sel = vic_ack_i[k];
                w_dat_sel = vic_dat_i[k*16 +: 16];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_rr    <= '0;
            r_cnt   <= '0;
            r_stb   <= '0;
            r_vec   <= '0;
            r_vrdy  <= 1'b0;
            r_verr  <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_sel   <= w_sel_n;
            r_rr    <= w_rr_n;
            r_cnt   <= w_cnt_n;
            r_stb   <= w_stb_n;
            r_vec   <= w_vec_n;
            r_vrdy  <= w_vrdy_n;
            r_verr  <= w_verr_n;
            r_irq   <= w_irq_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_sel_n   = r_sel;
        w_rr_n    = r_rr;
        w_cnt_n   = r_cnt;
        w_stb_n   = r_stb;
        w_vec_n   = r_vec;
        w_vrdy_n  = 1'b0;
        w_verr_n  = 1'b0;
        w_irq_n   = (r_state == IDLE) && w_elig;

        unique case (r_state)
            IDLE: begin
                if (cpu_iak_i) begin
                    if (w_elig) begin
                        w_sel_n = w_win;
                        w_cnt_n = '0;
                        for (int unsigned k = 0; k < M; k++) begin
                            w_stb_n[k] = (IW'(k) == w_win);
                        end
                        w_state_n = STB;
                    end else begin
                        w_verr_n  = 1'b1;
                        w_state_n = REL;
                    end
                end
            end
            STB: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (w_ack_sel) begin
                    w_vec_n   = w_dat_sel;
                    w_vrdy_n  = 1'b1;
                    w_stb_n   = '0;
                    w_rr_n    = (r_sel == IW'(M - 1)) ? '0 : r_sel + IW'(1);
                    w_state_n = REL;
                end else begin
                    w_cnt_n = r_cnt + TMO_W'(1);
                    if (w_cnt_n == TMO_W'(TMO)) begin
                        w_stb_n   = '0;
                        w_verr_n  = 1'b1;
                        w_state_n = REL;
                    end
                end
            end
            REL: begin
                if (!cpu_iak_i) begin
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_stb_n   = '0;
                w_state_n = IDLE;
            end
        endcase
    end

    assign cpu_irq_o  = r_irq;
    assign cpu_vec_o  = r_vec;
    assign cpu_vrdy_o = r_vrdy;
    assign cpu_verr_o = r_verr;
    assign vic_stb_o  = r_stb;

endmodule

// File: tb/tb_wbc_vic_arb.sv
// Randomized self-checking bench for wbc_vic_arb (M=2, TMO=15) against a
// transaction-level model of level select, round robin, ack and timeout.
module tb_wbc_vic_arb;

    localparam int M   = 2;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    cpu_pri = '0;
    logic          cpu_irq;
    logic          cpu_iak = 1'b0;
    logic [15:0]   cpu_vec;
    logic          cpu_vrdy;
    logic          cpu_verr;
    logic [M*4-1:0]  vic_irq = '0;
    logic [M-1:0]    vic_stb;
    logic [M-1:0]    vic_ack = '0;
    logic [M*16-1:0] vic_dat = '0;

    int checks = 0;
    int failures = 0;

    int          m_rr = 0;
    logic [15:0] m_vec = '0;

    wbc_vic_arb #(
        .M   (M),
        .TMO (TMO)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .cpu_pri_i  (cpu_pri),
        .cpu_irq_o  (cpu_irq),
        .cpu_iak_i  (cpu_iak),
        .cpu_vec_o  (cpu_vec),
        .cpu_vrdy_o (cpu_vrdy),
        .cpu_verr_o (cpu_verr),
        .vic_irq_i  (vic_irq),
        .vic_stb_o  (vic_stb),
        .vic_ack_i  (vic_ack),
        .vic_dat_i  (vic_dat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int level_of(input logic [3:0] v);
        for (int b = 3; b >= 0; b--) begin
            if (v[b]) return 4 + b;
        end
        return 0;
    endfunction

    // One full acknowledge cycle. d = cycles after strobe before ack is driven.
    task automatic do_txn(input logic [7:0] irqv, input logic [2:0] pri,
                          input int d, input logic [15:0] data, input bit noise);
        int lv[2];
        int maxl, win, relh;
        bit elig, done;
        logic [1:0] exp_stb;

        vic_irq = irqv;
        cpu_pri = pri;
        cpu_iak = 1'b0;
        vic_ack = '0;
        step();
        lv[0] = level_of(irqv[3:0]);
        lv[1] = level_of(irqv[7:4]);
        maxl  = (lv[0] > lv[1]) ? lv[0] : lv[1];
        elig  = (maxl > int'(pri));
        check("irq_pending", {31'b0, cpu_irq}, {31'b0, elig});

        win = m_rr;
        for (int i = 0; i < M; i++) begin
            if (lv[(m_rr + i) % M] == maxl) begin
                win = (m_rr + i) % M;
                break;
            end
        end
        exp_stb = 2'b01 << win;

        cpu_iak = 1'b1;
        step();
        if (!elig) begin
            check("noelig_verr", {31'b0, cpu_verr}, 32'd1);
            check("noelig_stb", {30'b0, vic_stb}, 32'd0);
            check("noelig_vrdy", {31'b0, cpu_vrdy}, 32'd0);
            cpu_iak = 1'b0;
            step();
            check("noelig_verr_pulse", {31'b0, cpu_verr}, 32'd0);
            return;
        end
        check("stb_onehot", {30'b0, vic_stb}, {30'b0, exp_stb});
        check("stb_verr", {31'b0, cpu_verr}, 32'd0);

        done = 1'b0;
        for (int j = 1; j <= TMO && !done; j++) begin
            vic_ack = (j - 1 == d) ? exp_stb : 2'b00;
            vic_dat = {$urandom, $urandom};
            if (j - 1 == d) vic_dat[win*16 +: 16] = data;
            if (noise) begin
                vic_ack[1 - win] = 1'($urandom);
                vic_irq = 8'($urandom);
            end
            step();
            check("irq_busy", {31'b0, cpu_irq}, 32'd0);
            if (j - 1 == d) begin
                check("ack_vrdy", {31'b0, cpu_vrdy}, 32'd1);
                check("ack_verr", {31'b0, cpu_verr}, 32'd0);
                check("ack_vec", {16'b0, cpu_vec}, {16'b0, data});
                check("ack_stb", {30'b0, vic_stb}, 32'd0);
                m_vec = data;
                m_rr  = (win + 1) % M;
                done  = 1'b1;
            end else if (j == TMO) begin
                check("tmo_verr", {31'b0, cpu_verr}, 32'd1);
                check("tmo_vrdy", {31'b0, cpu_vrdy}, 32'd0);
                check("tmo_stb", {30'b0, vic_stb}, 32'd0);
                check("tmo_vec", {16'b0, cpu_vec}, {16'b0, m_vec});
                done = 1'b1;
            end else begin
                check("wait_stb", {30'b0, vic_stb}, {30'b0, exp_stb});
                check("wait_vrdy", {31'b0, cpu_vrdy}, 32'd0);
            end
        end
        vic_ack = '0;

        relh = $urandom_range(0, 2);
        for (int r = 0; r < relh; r++) begin
            step();
            check("rel_stb", {30'b0, vic_stb}, 32'd0);
            check("rel_pulse", {30'b0, cpu_vrdy, cpu_verr}, 32'd0);
        end
        cpu_iak = 1'b0;
        step();
        check("rel_end_stb", {30'b0, vic_stb}, 32'd0);
    endtask

    initial begin
        #2;
        check("rst_irq", {31'b0, cpu_irq}, 32'd0);
        check("rst_stb", {30'b0, vic_stb}, 32'd0);
        check("rst_vec", {16'b0, cpu_vec}, 32'd0);
        check("rst_pulses", {30'b0, cpu_vrdy, cpu_verr}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        do_txn(8'h31, 3'd4, 2, 16'o000060, 1'b0);
        check("rr_after_first", m_rr, 32'd0);

        for (int i = 0; i < 3; i++) do_txn(8'h44, 3'd2, 1, 16'h1000 + 16'(i), 1'b0);

        do_txn(8'h44, 3'd7, 0, 16'h0, 1'b0);
        do_txn(8'h00, 3'd0, 0, 16'h0, 1'b0);

        do_txn(8'h88, 3'd3, 20, 16'hdead, 1'b0);
        do_txn(8'h88, 3'd3, TMO - 1, 16'hbeef, 1'b0);
        do_txn(8'h12, 3'd4, TMO, 16'hcafe, 1'b1);

        for (int n = 0; n < 60; n++) begin
            do_txn(8'($urandom), 3'($urandom), $urandom_range(0, TMO + 2),
                   16'($urandom), 1'($urandom));
        end

        vic_irq = 8'h40;
        cpu_pri = 3'd0;
        step();
        cpu_iak = 1'b1;
        step();
        check("prerst_stb", {30'b0, vic_stb}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_stb", {30'b0, vic_stb}, 32'd0);
        check("midrst_irq", {31'b0, cpu_irq}, 32'd0);
        check("midrst_vec", {16'b0, cpu_vec}, 32'd0);
        check("midrst_pulses", {30'b0, cpu_vrdy, cpu_verr}, 32'd0);
        cpu_iak = 1'b0;
        m_rr  = 0;
        m_vec = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("postrst_pulses", {30'b0, cpu_vrdy, cpu_verr}, 32'd0);
        do_txn(8'h55, 3'd1, 3, 16'h5a5a, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
